// File: rtl/main_file_cpu_oci_trace_capture.sv
// OCI DCT trace capture: FWFT FIFO with valid/ready drain, saturating drop counter
// and RUN/FLUSH/DONE end-of-test sequencer. Optional macro: TRACE_TIMESTAMP_EN.
module main_file_cpu_oci_trace_capture #(
    parameter int DCT_W = 30,
    parameter int CNT_W = 4,
    parameter int DEPTH = 16,
    parameter int OVF_W = 8,
    parameter int TS_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    dct_valid,
    input  logic [DCT_W-1:0]        dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    output logic                    trc_valid,
    input  logic                    trc_ready,
    output logic [DCT_W-1:0]        trc_data,
    output logic [CNT_W-1:0]        trc_count,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]         trc_tstamp,
`endif
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [OVF_W-1:0]        overflow_cnt,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = DCT_W + CNT_W + TS_W;
`else
    localparam int ENTRY_W = DCT_W + CNT_W;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_check
        $error("main_file_cpu_oci_trace_capture: DEPTH must be a power of two >= 2, TS_W >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign full      = (fill_level == LVL_W'(DEPTH));
    assign trc_valid = (fill_level != '0);
    assign pop       = trc_valid & trc_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push      = dct_valid & (state_q == ST_RUN) & (~full | pop);
    assign drop      = dct_valid & (state_q == ST_RUN) & full & ~pop;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 1'b1;
    end

    assign wr_entry   = {ts_cnt, dct_count, dct_buffer};
    assign trc_tstamp = trc_valid ? head[ENTRY_W-1 -: TS_W] : '0;
`else
    assign wr_entry   = {dct_count, dct_buffer};
`endif

    // Head outputs are gated so an empty FIFO presents zeros, including after reset.
    assign head      = mem[rd_ptr];
    assign trc_data  = trc_valid ? head[DCT_W-1:0] : '0;
    assign trc_count = trc_valid ? head[DCT_W +: CNT_W] : '0;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            if (drop) overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            done    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (test_ending || test_has_ended) state_q <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // The pop that empties the FIFO completes the drain in the same cycle.
                    if (test_has_ended &&
                        (fill_level == '0 || (fill_level == LVL_W'(1) && pop))) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_RUN;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_file_cpu_oci_trace_capture.sv
// Bench for main_file_cpu_oci_trace_capture: vector table with per-cycle expectations
// plus a FIFO scoreboard; timestamp sequence runs when TRACE_TIMESTAMP_EN is defined.
module tb_main_file_cpu_oci_trace_capture;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int OVF_W = 8;
    localparam int TS_W  = 32;

    logic                   clk;
    logic                   reset_n;
    logic                   dct_valid;
    logic [DCT_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]       dct_count;
    logic                   test_ending;
    logic                   test_has_ended;
    logic                   trc_valid;
    logic                   trc_ready;
    logic [DCT_W-1:0]       trc_data;
    logic [CNT_W-1:0]       trc_count;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]        trc_tstamp;
`endif
    logic [$clog2(DEPTH):0] fill_level;
    logic [OVF_W-1:0]       overflow_cnt;
    logic [1:0]             state;
    logic                   done;

    main_file_cpu_oci_trace_capture #(
        .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W), .TS_W(TS_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .dct_valid(dct_valid),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count),
        .test_ending(test_ending),
        .test_has_ended(test_has_ended),
        .trc_valid(trc_valid),
        .trc_ready(trc_ready),
        .trc_data(trc_data),
        .trc_count(trc_count),
`ifdef TRACE_TIMESTAMP_EN
        .trc_tstamp(trc_tstamp),
`endif
        .fill_level(fill_level),
        .overflow_cnt(overflow_cnt),
        .state(state),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               rst;
        bit               v;
        logic [DCT_W-1:0] d;
        logic [CNT_W-1:0] c;
        bit               rdy;
        bit               te;
        bit               th;
        int               lvl;
        int               ovf;
        logic [1:0]       st;
    } vec_t;

    typedef struct {
        logic [DCT_W-1:0] d;
        logic [CNT_W-1:0] c;
    } item_t;

    vec_t  vecs[$];
    item_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void add(bit rst, bit v, logic [DCT_W-1:0] d, logic [CNT_W-1:0] c,
                                bit rdy, bit te, bit th, int lvl, int ovf, logic [1:0] st);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.c = c; t.rdy = rdy; t.te = te; t.th = th;
        t.lvl = lvl; t.ovf = ovf; t.st = st;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; trc_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trc_valid", 64'(trc_valid), 64'd0);
        chk("rst_fill_level", 64'(fill_level), 64'd0);
        chk("rst_overflow", 64'(overflow_cnt), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_trc_data", 64'(trc_data), 64'd0);
        reset_n = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int    prev_lvl;
        bit    pop;
        bit    acc;
        item_t it;

        reset_n = 1'b0;
        clear_inputs();

        // Single word, held then drained
        add(0, 1, 30'h1234567, 4'd3, 0, 0, 0, 1, 0, 2'b00);
        add(0, 0, '0, '0, 1, 0, 0, 0, 0, 2'b00);
        // Overfill: 16 stored, 4 dropped; push+pop at full; then drain
        for (int i = 0; i < 20; i++)
            add(0, 1, DCT_W'(32'h100 + i), CNT_W'(i), 0, 0, 0,
                (i < 16) ? i + 1 : 16, (i < 16) ? 0 : i - 15, 2'b00);
        add(0, 1, 30'h2ABCDEF0, 4'hF, 1, 0, 0, 16, 4, 2'b00);
        for (int i = 0; i < 16; i++)
            add(0, 0, '0, '0, 1, 0, 0, 15 - i, 4, 2'b00);
        // End-of-test: word on the test_ending edge kept, later pushes ignored, drain to DONE
        for (int i = 0; i < 5; i++)
            add(i == 0, 1, DCT_W'(32'h200 + i), CNT_W'(i), 0, 0, 0, i + 1, 0, 2'b00);
        add(0, 1, 30'h3ABCDE5, 4'h5, 0, 1, 0, 6, 0, 2'b01);
        for (int i = 0; i < 3; i++)
            add(0, 1, 30'h999, 4'h9, 0, 1, 0, 6, 0, 2'b01);
        for (int i = 0; i < 6; i++)
            add(0, 0, '0, '0, 1, 1, 1, 5 - i, 0, (i == 5) ? 2'b10 : 2'b01);
        add(0, 1, 30'h777, 4'h7, 1, 1, 1, 0, 0, 2'b10);
        // 300 drops saturate the counter, then enter FLUSH
        for (int i = 0; i < 316; i++)
            add(i == 0, 1, DCT_W'(32'h1000 + i), CNT_W'(i), 0, 0, 0,
                (i < 16) ? i + 1 : 16, (i < 16) ? 0 : ((i - 15 > 255) ? 255 : i - 15), 2'b00);
        add(0, 1, 30'h5, 4'h1, 0, 1, 0, 16, 255, 2'b01);
        add(0, 0, '0, '0, 1, 0, 0, 15, 255, 2'b01);

        do_reset();
        prev_lvl = 0;

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) begin
                do_reset();
                prev_lvl = 0;
            end
            dct_valid      = vecs[k].v;
            dct_buffer     = vecs[k].d;
            dct_count      = vecs[k].c;
            trc_ready      = vecs[k].rdy;
            test_ending    = vecs[k].te;
            test_has_ended = vecs[k].th;

            pop = vecs[k].rdy && (prev_lvl != 0);
            if (pop) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd0, 64'd1);
                end else begin
                    it = sb_q.pop_front();
                    chk("pop_data", 64'(trc_data), 64'(it.d));
                    chk("pop_count", 64'(trc_count), 64'(it.c));
                end
            end
            acc = vecs[k].v && ((vecs[k].lvl - prev_lvl + (pop ? 1 : 0)) == 1);
            if (acc) begin
                it.d = vecs[k].d;
                it.c = vecs[k].c;
                sb_q.push_back(it);
            end

            @(posedge clk);
            #1;
            chk("fill_level", 64'(fill_level), 64'(vecs[k].lvl));
            chk("overflow_cnt", 64'(overflow_cnt), 64'(vecs[k].ovf));
            chk("state", 64'(state), 64'(vecs[k].st));
            chk("done", 64'(done), 64'(vecs[k].st == 2'b10));
            chk("trc_valid", 64'(trc_valid), 64'(vecs[k].lvl != 0));
            if (sb_q.size() != 0) begin
                chk("head_data", 64'(trc_data), 64'(sb_q[0].d));
                chk("head_count", 64'(trc_count), 64'(sb_q[0].c));
            end
            prev_lvl = vecs[k].lvl;
        end

        // Asynchronous reset in the middle of FLUSH, no clock edge needed
        clear_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_fill_level", 64'(fill_level), 64'd0);
        chk("async_overflow", 64'(overflow_cnt), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_trc_valid", 64'(trc_valid), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_q.delete();
        dct_valid = 1'b1; dct_buffer = 30'h0ABC; dct_count = 4'h2;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        chk("post_rst_level", 64'(fill_level), 64'd1);
        chk("post_rst_data", 64'(trc_data), 64'h0ABC);
        chk("post_rst_state", 64'(state), 64'd0);

`ifdef TRACE_TIMESTAMP_EN
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        dct_valid = 1'b1; dct_buffer = 30'h10; dct_count = 4'h1;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dct_valid = 1'b1; dct_buffer = 30'h13; dct_count = 4'h2;
        @(posedge clk);
        #1;
        dct_valid = 1'b0;
        chk("tstamp_first", 64'(trc_tstamp), 64'd10);
        trc_ready = 1'b1;
        @(posedge clk);
        #1;
        trc_ready = 1'b0;
        chk("tstamp_second", 64'(trc_tstamp), 64'd13);
        chk("tstamp_second_data", 64'(trc_data), 64'h13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
